// File: rtl/mdu_pkg.sv
// Shared encodings and helpers for the multiply/divide unit.
// Build option: define MDU_MADD_EN to enable madd/maddu/msub/msubu (ops 4-7).
package mdu_pkg;

   localparam logic [3:0] MDU_OP_MULT  = 4'd0;
   localparam logic [3:0] MDU_OP_MULTU = 4'd1;
   localparam logic [3:0] MDU_OP_DIV   = 4'd2;
   localparam logic [3:0] MDU_OP_DIVU  = 4'd3;
   localparam logic [3:0] MDU_OP_MADD  = 4'd4;
   localparam logic [3:0] MDU_OP_MADDU = 4'd5;
   localparam logic [3:0] MDU_OP_MSUB  = 4'd6;
   localparam logic [3:0] MDU_OP_MSUBU = 4'd7;

   function automatic logic is_div(input logic [3:0] op);
      return (op == MDU_OP_DIV) || (op == MDU_OP_DIVU);
   endfunction

   function automatic logic is_signed_op(input logic [3:0] op);
      return (op == MDU_OP_MULT) || (op == MDU_OP_DIV) ||
             (op == MDU_OP_MADD) || (op == MDU_OP_MSUB);
   endfunction

   function automatic logic is_valid_op(input logic [3:0] op);
`ifdef MDU_MADD_EN
      return op <= MDU_OP_MSUBU;
`else
      return op <= MDU_OP_DIVU;
`endif
   endfunction

   function automatic int cnt_width(input int mult_lat, input int div_lat);
      return $clog2(((mult_lat > div_lat) ? mult_lat : div_lat) + 1);
   endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath: sign handling, divide-by-zero and
// overflow rules, and (with MDU_MADD_EN) the 2*WIDTH accumulate adder.
module mdu_arith
   import mdu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] hi,
   input  logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] res_hi,
   output logic [WIDTH-1:0] res_lo
);

   logic               sgn;
   logic [2*WIDTH-1:0] a_ext;
   logic [2*WIDTH-1:0] b_ext;
   logic [2*WIDTH-1:0] prod;
   logic               a_neg;
   logic               b_neg;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic [WIDTH-1:0]   q_mag;
   logic [WIDTH-1:0]   r_mag;
   logic [WIDTH-1:0]   quot;
   logic [WIDTH-1:0]   rem;
   logic [2*WIDTH-1:0] result;

   assign sgn   = is_signed_op(op);
   assign a_ext = sgn ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
   assign b_ext = sgn ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
   // Low 2*WIDTH bits of the extended product are exact for both signednesses.
   assign prod  = a_ext * b_ext;

   // Sign-magnitude division; INT_MIN / -1 naturally yields INT_MIN rem 0.
   assign a_neg = sgn & a[WIDTH-1];
   assign b_neg = sgn & b[WIDTH-1];
   assign a_mag = a_neg ? -a : a;
   assign b_mag = b_neg ? -b : b;
   assign q_mag = (b_mag == '0) ? '0 : (a_mag / b_mag);
   assign r_mag = (b_mag == '0) ? '0 : (a_mag % b_mag);
   assign quot  = (a_neg ^ b_neg) ? -q_mag : q_mag;
   assign rem   = a_neg ? -r_mag : r_mag;

   always_comb begin
      result = prod;
      if (is_div(op)) begin
         if (b == '0) result = {a, {WIDTH{1'b1}}};
         else         result = {rem, quot};
      end
`ifdef MDU_MADD_EN
      else if ((op == MDU_OP_MSUB) || (op == MDU_OP_MSUBU)) begin
         result = {hi, lo} - prod;
      end else if ((op == MDU_OP_MADD) || (op == MDU_OP_MADDU)) begin
         result = {hi, lo} + prod;
      end
`endif
   end

`ifndef MDU_MADD_EN
   logic unused_acc;
   assign unused_acc = ^{hi, lo};
`endif

   assign res_hi = result[2*WIDTH-1:WIDTH];
   assign res_lo = result[WIDTH-1:0];

endmodule

// File: rtl/mdu_unit.sv
// Multi-cycle MIPS multiply/divide unit: latency counter, pending result,
// HI/LO registers, mthi/mtlo arbitration and read mux. Option: MDU_MADD_EN.
module mdu_unit
   import mdu_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int MULT_LAT = 5,
   parameter int DIV_LAT  = 10
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [3:0]       mdu_op,
   input  logic [WIDTH-1:0] rs_val,
   input  logic [WIDTH-1:0] rt_val,
   input  logic             hi_write,
   input  logic             lo_write,
   input  logic             lo_sel,
   output logic [WIDTH-1:0] rd_data,
   output logic             busy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CNT_W = cnt_width(MULT_LAT, DIV_LAT);

   logic [CNT_W-1:0] counter_reg;
   logic [WIDTH-1:0] pend_hi_reg;
   logic [WIDTH-1:0] pend_lo_reg;
   logic [WIDTH-1:0] hi_reg;
   logic [WIDTH-1:0] lo_reg;
   logic [WIDTH-1:0] arith_hi;
   logic [WIDTH-1:0] arith_lo;
   logic             accept;
   logic             commit;
   logic             mt_ok;

   mdu_arith #(.WIDTH(WIDTH)) u_arith (
      .op     (mdu_op),
      .a      (rs_val),
      .b      (rt_val),
      .hi     (hi_reg),
      .lo     (lo_reg),
      .res_hi (arith_hi),
      .res_lo (arith_lo)
   );

   assign busy   = (counter_reg != '0);
   assign accept = start & ~busy & is_valid_op(mdu_op);
   assign commit = (counter_reg == CNT_W'(1));
   // Any start, even an invalid one, blocks mthi/mtlo in the same cycle.
   assign mt_ok  = ~busy & ~start;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         counter_reg <= '0;
         pend_hi_reg <= '0;
         pend_lo_reg <= '0;
      end else if (accept) begin
         counter_reg <= is_div(mdu_op) ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
         pend_hi_reg <= arith_hi;
         pend_lo_reg <= arith_lo;
      end else if (busy) begin
         counter_reg <= counter_reg - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hi_reg <= '0;
         lo_reg <= '0;
      end else if (commit) begin
         hi_reg <= pend_hi_reg;
         lo_reg <= pend_lo_reg;
      end else if (mt_ok) begin
         if (hi_write) hi_reg <= rs_val;
         if (lo_write) lo_reg <= rs_val;
      end
   end

   assign rd_data = lo_sel ? lo_reg : hi_reg;
   assign hi      = hi_reg;
   assign lo      = lo_reg;

endmodule

// File: tb/tb_mdu_unit.sv
// Directed self-checking bench for mdu_unit with default parameters.
module tb_mdu_unit;
   import mdu_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic [3:0]  mdu_op;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        hi_write;
   logic        lo_write;
   logic        lo_sel;
   logic [31:0] rd_data;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   int total  = 0;
   int passed = 0;
   int n;

   mdu_unit #(.WIDTH(32), .MULT_LAT(5), .DIV_LAT(10)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (start),
      .mdu_op   (mdu_op),
      .rs_val   (rs_val),
      .rt_val   (rt_val),
      .hi_write (hi_write),
      .lo_write (lo_write),
      .lo_sel   (lo_sel),
      .rd_data  (rd_data),
      .busy     (busy),
      .hi       (hi),
      .lo       (lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
   endtask

   // Hazard logic upstream must never launch while busy.
   always @(posedge clk) begin
      if (reset_n === 1'b1 && start === 1'b1 && busy === 1'b1) begin
         total++;
         $error("FAIL hazard: start=1 observed while busy=1");
      end
   end

   // Called at a negedge; drives start for one cycle, returns at the next negedge.
   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      start  = 1'b1;
      mdu_op = op;
      rs_val = a;
      rt_val = b;
      @(negedge clk);
      start  = 1'b0;
      rs_val = '0;
      rt_val = '0;
   endtask

   task automatic wait_idle(output int cnt);
      cnt = 0;
      while (busy && cnt < 100) begin
         cnt++;
         @(negedge clk);
      end
   endtask

   task automatic mt(input logic wr_hi, input logic wr_lo, input logic [31:0] v);
      hi_write = wr_hi;
      lo_write = wr_lo;
      rs_val   = v;
      @(negedge clk);
      hi_write = 1'b0;
      lo_write = 1'b0;
      rs_val   = '0;
   endtask

   initial begin
      reset_n  = 1'b0;
      start    = 1'b0;
      mdu_op   = '0;
      rs_val   = '0;
      rt_val   = '0;
      hi_write = 1'b0;
      lo_write = 1'b0;
      lo_sel   = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      check("reset_hi", hi, 32'h0);
      check("reset_lo", lo, 32'h0);
      check("reset_busy", {31'b0, busy}, 32'h0);
      check("reset_rd", rd_data, 32'h0);

      // mult -3 * 7
      issue(MDU_OP_MULT, 32'hFFFF_FFFD, 32'd7);
      check("mult_hi_pending", hi, 32'h0);
      wait_idle(n);
      check("mult_busy_cycles", n, 32'd5);
      check("mult_hi", hi, 32'hFFFF_FFFF);
      check("mult_lo", lo, 32'hFFFF_FFEB);
      lo_sel = 1'b1;
      #1 check("mult_rd_lo", rd_data, 32'hFFFF_FFEB);
      lo_sel = 1'b0;
      #1 check("mult_rd_hi", rd_data, 32'hFFFF_FFFF);

      // divu 100/7 then back-to-back div -7/2
      @(negedge clk);
      issue(MDU_OP_DIVU, 32'd100, 32'd7);
      wait_idle(n);
      check("divu_busy_cycles", n, 32'd10);
      check("divu_hi", hi, 32'd2);
      check("divu_lo", lo, 32'd14);
      issue(MDU_OP_DIV, 32'hFFFF_FFF9, 32'd2);
      check("b2b_accepted", {31'b0, busy}, 32'h1);
      wait_idle(n);
      check("div_busy_cycles", n, 32'd10);
      check("div_lo", lo, 32'hFFFF_FFFD);
      check("div_hi", hi, 32'hFFFF_FFFF);

      // divide by zero and signed overflow
      issue(MDU_OP_DIV, 32'd5, 32'd0);
      wait_idle(n);
      check("div0_lo", lo, 32'hFFFF_FFFF);
      check("div0_hi", hi, 32'd5);
      issue(MDU_OP_DIVU, 32'd7, 32'd0);
      wait_idle(n);
      check("divu0_lo", lo, 32'hFFFF_FFFF);
      check("divu0_hi", hi, 32'd7);
      issue(MDU_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_idle(n);
      check("ovf_lo", lo, 32'h8000_0000);
      check("ovf_hi", hi, 32'h0);
      issue(MDU_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_idle(n);
      check("multu_hi", hi, 32'hFFFF_FFFE);
      check("multu_lo", lo, 32'h0000_0001);

      // mthi while busy is dropped
      issue(MDU_OP_MULT, 32'd2, 32'd3);
      mt(1'b1, 1'b0, 32'h0000_1234);
      wait_idle(n);
      check("mthi_busy_hi", hi, 32'h0);
      check("mthi_busy_lo", lo, 32'd6);

      // mtlo while idle
      mt(1'b0, 1'b1, 32'h0000_ABCD);
      lo_sel = 1'b1;
      #1 check("mtlo_lo", lo, 32'h0000_ABCD);
      check("mtlo_rd", rd_data, 32'h0000_ABCD);
      check("mtlo_hi", hi, 32'h0);
      lo_sel = 1'b0;

      // start and mthi in the same cycle: only the op lands
      hi_write = 1'b1;
      issue(MDU_OP_MULTU, 32'h1234_0000, 32'h0000_0010);
      hi_write = 1'b0;
      check("collide_hi_now", hi, 32'h0);
      wait_idle(n);
      check("collide_hi", hi, 32'h0000_0001);
      check("collide_lo", lo, 32'h2340_0000);

      // mthi and mtlo together
      mt(1'b1, 1'b1, 32'h0000_0055);
      check("both_hi", hi, 32'h55);
      check("both_lo", lo, 32'h55);

      // invalid op
      issue(4'd8, 32'd3, 32'd3);
      check("invalid_busy", {31'b0, busy}, 32'h0);
      check("invalid_lo", lo, 32'h55);

      // reset in cycle 3 of a div aborts it
      issue(MDU_OP_DIV, 32'd100, 32'd7);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("abort_hi", hi, 32'h0);
      check("abort_lo", lo, 32'h0);
      check("abort_busy", {31'b0, busy}, 32'h0);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (12) @(negedge clk);
      check("abort_late_hi", hi, 32'h0);
      check("abort_late_lo", lo, 32'h0);
      check("abort_late_busy", {31'b0, busy}, 32'h0);

      // maddu 1*1 onto HI=0, LO=all-ones
      mt(1'b0, 1'b1, 32'hFFFF_FFFF);
      mt(1'b1, 1'b0, 32'h0);
      issue(MDU_OP_MADDU, 32'd1, 32'd1);
`ifdef MDU_MADD_EN
      wait_idle(n);
      check("maddu_busy_cycles", n, 32'd5);
      check("maddu_hi", hi, 32'h1);
      check("maddu_lo", lo, 32'h0);
      issue(MDU_OP_MSUB, 32'd2, 32'hFFFF_FFFF);
      wait_idle(n);
      check("msub_hi", hi, 32'h1);
      check("msub_lo", lo, 32'h2);
`else
      check("maddu_off_busy", {31'b0, busy}, 32'h0);
      repeat (6) @(negedge clk);
      check("maddu_off_hi", hi, 32'h0);
      check("maddu_off_lo", lo, 32'hFFFF_FFFF);
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
